// File: rtl/rr_mux_reg_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// Latency: none, this is wiring only.
// Backpressure: carries in_ready per producer and out_ready from the consumer.
//   in_data/in_valid/in_ready : N producer channels, channel i at in_data[i*W +: W]
//   force_en/force_sel        : bypass arbitration and expose a single channel
//   out_data/out_sel/out_valid/out_ready : registered output to the consumer
interface rr_mux_reg_if #(
    parameter int W = 32,
    parameter int N = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             force_en;
    logic [SEL_W-1:0] force_sel;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side (drives requests, consumes the output register)
    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Mux side
    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel arbitrated mux (round-robin or fixed priority, optional forced select) into a one-entry output register.
// Latency: one cycle from in_valid&in_ready to out_valid/out_data.
// Backpressure: out_valid&~out_ready drops every in_ready and holds the register; drain and refill may share a cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rr_mux_reg_if slave (producer channels, force controls, registered output)
module rr_mux_reg #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_reg_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]     elig;
    logic             found;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_dat;
    logic [N-1:0]     grant;
    logic             load;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // Eligibility. A forced index that names no channel (only possible when N
    // is not a power of two) matches no k, so nothing becomes eligible.
    always_comb begin
        elig = '0;
        if (bus.force_en) begin
            for (int k = 0; k < N; k++) begin
                if (int'(bus.force_sel) == k) begin
                    elig[k] = bus.in_valid[k];
                end
            end
        end else begin
            elig = bus.in_valid;
        end
    end

    // Arbitration: scan N candidates starting at ptr (round-robin) or at 0
    // (fixed priority); the first eligible candidate wins.
    always_comb begin
        int cand;
        cand    = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = (RR != 0) ? int'(ptr_q) + k : k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(cand);
            end
        end
    end

    // Winner's data and one-hot grant
    always_comb begin
        gnt_dat = '0;
        grant   = '0;
        for (int k = 0; k < N; k++) begin
            if (found && int'(gnt_idx) == k) begin
                gnt_dat  = bus.in_data[k*W +: W];
                grant[k] = 1'b1;
            end
        end
    end

    assign load = ~out_valid_q | bus.out_ready;

    // No acceptance while reset is held so nothing is lost into a flop that
    // cannot capture it.
    assign bus.in_ready = (load && rst_n) ? grant : '0;

    // Output register and pointer next-state. A grant under load is always a
    // transfer because grant implies in_valid.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_data_d = gnt_dat;
                out_sel_d  = gnt_idx;
                // Forced grants leave the rotation untouched
                if (RR != 0 && !bus.force_en) begin
                    ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule
